axi_rd_mem_slave: RTL and testbench
===================================

# axi_rd_mem_slave

Synthesizable AXI4 read-only memory slave that sits directly downstream of the AXI VIP master agent and gives it a real RTL target for read traffic. It accepts AR requests, returns R bursts from an internal word array, and echoes IDs. It also supplies OKAY/SLVERR/DECERR responses that the VIP monitor checks. The array is preloaded through a backdoor write port.

## Interface
- ADDR_W, 16: byte-address width of araddr
- DATA_W, 32: data width in bits; power of two, ≥ 8
- ID_W, 4: width of arid/rid
- DEPTH, 1024: number of DATA_W words in the array
- clk  in  1  sole clock; all logic is rising-edge
- rst  in  1  asynchronous, active-high reset
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- arid  in  ID_W  transaction ID
- araddr  in  ADDR_W  start byte address
- arlen  in  8  beats minus one
- arburst  in  2  0 FIXED, 1 INCR, 2 WRAP, 3 reserved
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- rid  out  ID_W  ID of the current burst
- rdata  out  DATA_W  read data
- rresp  out  2  0 OKAY, 2 SLVERR, 3 DECERR
- rlast  out  1  final beat of the burst
- bd_we  in  1  backdoor write strobe
- bd_addr  in  $clog2(DEPTH)  backdoor word index
- bd_wdata  in  DATA_W  backdoor write data

## Operation
- AR queue: 2-entry FIFO. `arready = !full && !rst`. An AR handshake occurs when `arvalid && arready`.
- Read FSM states are IDLE and BURST.
  - IDLE → BURST when the queue is non-empty. The FSM pops the head entry and loads addr, beat count, id and burst type.
  - BURST → IDLE on the handshake of the rlast beat.
  - BURST → BURST (next burst) when the queue is non-empty at that same handshake, with no bubble.
- Address handling:
  - The byte address is aligned down to DATA_W/8. Word index = aligned address / (DATA_W/8).
  - FIXED: the address stays constant for every beat.
  - INCR: the address advances by DATA_W/8 per beat.
  - WRAP: see Configuration.
  - Arithmetic is ADDR_W bits and wraps modulo 2^ADDR_W. 4 KB crossings are not checked.
- Responses:
  - Word index ≥ DEPTH: that beat returns DECERR with rdata = 0. This is evaluated per beat.
  - arburst = 3: every beat returns SLVERR with rdata = 0.
  - Otherwise the beat returns OKAY.
- rlast is asserted when the beat counter equals arlen.
- Backdoor: the array is written on `bd_we`. A read of the same word in the same cycle returns the old data.

## Timing
- Reset values: arready 0, rvalid 0, rlast 0, rid 0, rdata 0, rresp 0.
  - The queue and FSM are cleared; the array is not reset.
  - arready rises the first cycle after rst deasserts.
- Latency: an AR handshake in cycle N with an empty queue and an IDLE FSM gives the first rvalid in cycle N+1. The array read is registered.
- Back-to-back: with rready held high, one beat is delivered per cycle, including across burst boundaries.
- Backpressure: while `rvalid && !rready`, rdata, rresp, rid and rlast stay stable. The next word is not fetched.
- Throughput: when the queue is full, arready drops in the cycle after the second acceptance. It rises again the cycle after a pop.
- Simultaneous push and pop on a full queue is not allowed: arready is 0 when full.
- Reset mid-burst: the burst and queued requests are dropped and rvalid is 0 immediately. No rlast is owed.

## Configuration
- `AXI_RD_WRAP_EN` defined:
  - WRAP is supported. Wrap size = (arlen+1)·DATA_W/8.
  - The address wraps to the aligned-down wrap boundary.
  - arlen must be 1, 3, 7 or 15. Any other arlen returns SLVERR on every beat.
- `AXI_RD_WRAP_EN` undefined: WRAP is treated as reserved and every beat returns SLVERR with rdata = 0.

## Structure
- Package `axi_mem_pkg` holds:
  - `axi_burst_e` (FIXED/INCR/WRAP/RSVD)
  - `axi_resp_e` (OKAY/EXOKAY/SLVERR/DECERR)
  - `ar_req_t` struct (id, addr, len, burst)
  - the constant `AXI_AR_Q_DEPTH = 2`
- Sub-module `axi_rd_addr_gen`: combinational next-address and response classification. Inputs are the current address, burst, len and beat count. Outputs are the next address and the beat response.

## Test plan
- Preload word k = 32'hA000_0000+k. INCR at araddr 0x10, arlen 3, arid 5 → 4 beats A0000004..A0000007, rid 5, OKAY, rlast on beat 4, first rvalid at N+1.
- FIXED at araddr 0x20, arlen 2 → three beats of A0000008. Hold rready low for 3 cycles mid-burst → outputs stable.
- Two ARs back-to-back (ids 1 and 2, arlen 0) with a third pending → arready low after the second, and the R beats appear with no idle cycle between the bursts.
- INCR at araddr 0x0FF8, arlen 3, DEPTH 1024 → beats 1–2 OKAY, beats 3–4 DECERR with rdata 0.
- WRAP at araddr 0x18, arlen 3:
  - with `AXI_RD_WRAP_EN` → words 6, 7, 4, 5, OKAY; arlen 2 → SLVERR ×3.
  - without `AXI_RD_WRAP_EN` → SLVERR ×4.
- Assert rst during beat 2 of an 8-beat burst → rvalid 0 immediately. After release, a new AR gets a correct, full response.

Source files
------------

// File: rtl/axi_mem_pkg.sv
// Shared types and constants for the AXI4 read-only memory slave.
// Contents: burst/response enums, the queued AR request payload, the AR queue
// depth and a WRAP-length legality helper.
package axi_mem_pkg;

    localparam int unsigned AXI_AR_Q_DEPTH = 2;
    // Payload widths of a queued request; the top's ID_W/ADDR_W must not exceed these.
    localparam int unsigned AXI_ID_W       = 4;
    localparam int unsigned AXI_ADDR_W     = 16;
    localparam int unsigned AXI_LEN_W      = 8;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } axi_resp_e;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [AXI_LEN_W-1:0]  len;
        axi_burst_e            burst;
    } ar_req_t;

    // WRAP bursts are only legal for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [AXI_LEN_W-1:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_rd_addr_gen.sv
// Combinational beat classifier and next-address generator.
// Optional feature macro: AXI_RD_WRAP_EN (WRAP bursts supported when defined,
// otherwise WRAP is answered with SLVERR like the reserved encoding).
// Ports:
//   addr      in   byte address of the beat being issued
//   burst     in   burst type of the transaction
//   len       in   arlen of the transaction (beats minus one)
//   cnt       in   index of the beat being issued
//   next_addr out  byte address of the following beat
//   resp      out  response for the beat being issued
module axi_rd_addr_gen
    import axi_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024
)(
    input  logic [ADDR_W-1:0] addr,
    input  axi_burst_e        burst,
    input  logic [7:0]        len,
    input  logic [7:0]        cnt,
    output logic [ADDR_W-1:0] next_addr,
    output axi_resp_e         resp
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned LSB   = $clog2(BYTES);

    logic [ADDR_W-1:0] aligned;
    logic [ADDR_W-1:0] step;
    logic              out_of_range;

    // Beats are word granular: low byte-offset bits are dropped.
    assign aligned      = addr & ~ADDR_W'(BYTES - 1);
    assign step         = aligned + ADDR_W'(BYTES);
    assign out_of_range = (64'(aligned) >> LSB) >= 64'(DEPTH);

`ifdef AXI_RD_WRAP_EN
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] wrap_next;

    // Wrap window is (len+1) words; the incremented offset folds back into it.
    assign wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << LSB) - ADDR_W'(1);
    assign wrap_next = (aligned & ~wrap_mask) | (step & wrap_mask);
`endif

    // Next address; held after the final beat since nothing consumes it.
    always_comb begin
        next_addr = aligned;
        if (cnt != len) begin
            case (burst)
                BURST_FIXED: next_addr = aligned;
                BURST_INCR:  next_addr = step;
`ifdef AXI_RD_WRAP_EN
                BURST_WRAP:  next_addr = wrap_next;
`endif
                default:     next_addr = aligned;
            endcase
        end
    end

    // Burst-type errors take priority over the per-beat decode error.
    always_comb begin
        resp = RESP_OKAY;
        case (burst)
            BURST_RSVD: resp = RESP_SLVERR;
            BURST_WRAP: begin
`ifdef AXI_RD_WRAP_EN
                if (!wrap_len_ok(len)) begin
                    resp = RESP_SLVERR;
                end else if (out_of_range) begin
                    resp = RESP_DECERR;
                end
`else
                resp = RESP_SLVERR;
`endif
            end
            default: begin
                if (out_of_range) begin
                    resp = RESP_DECERR;
                end
            end
        endcase
    end

endmodule

// File: rtl/axi_rd_mem_slave.sv
// AXI4 read-only memory slave: 2-entry AR queue, IDLE/BURST read FSM,
// registered word-array read and a backdoor preload port.
// Optional feature macro: AXI_RD_WRAP_EN (enables WRAP bursts).
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   arvalid/arready/arid/araddr/
//   arlen/arburst                 AXI read-address channel
//   rvalid/rready/rid/rdata/
//   rresp/rlast                   AXI read-data channel (all registered)
//   bd_we/bd_addr/bd_wdata        backdoor word write into the array
module axi_rd_mem_slave
    import axi_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned DEPTH  = 1024
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arvalid,
    output logic                     arready,
    input  logic [ID_W-1:0]          arid,
    input  logic [ADDR_W-1:0]        araddr,
    input  logic [7:0]               arlen,
    input  logic [1:0]               arburst,
    output logic                     rvalid,
    input  logic                     rready,
    output logic [ID_W-1:0]          rid,
    output logic [DATA_W-1:0]        rdata,
    output logic [1:0]               rresp,
    output logic                     rlast,
    input  logic                     bd_we,
    input  logic [$clog2(DEPTH)-1:0] bd_addr,
    input  logic [DATA_W-1:0]        bd_wdata
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned LSB    = $clog2(DATA_W / 8);
    localparam int unsigned QPTR_W = $clog2(AXI_AR_Q_DEPTH);
    localparam int unsigned QCNT_W = QPTR_W + 1;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_e;

    state_e              state;
    state_e              state_n;

    ar_req_t             q_mem [AXI_AR_Q_DEPTH];
    logic [QPTR_W-1:0]   wr_ptr;
    logic [QPTR_W-1:0]   rd_ptr;
    logic [QCNT_W-1:0]   count;
    logic                full;
    logic                empty;
    logic                ar_hs;
    logic                push;
    logic                pop;
    ar_req_t             ar_in;
    ar_req_t             head;
    ar_req_t             start_src;
    logic                start_avail;

    logic                beat_hs;
    logic                start;
    logic                advance;
    logic                load;

    logic [ADDR_W-1:0]   nxt_addr;
    logic [7:0]          cnt;
    logic [7:0]          ctx_len;
    axi_burst_e          ctx_burst;
    logic [ID_W-1:0]     ctx_id;

    logic [ADDR_W-1:0]   sel_addr;
    axi_burst_e          sel_burst;
    logic [7:0]          sel_len;
    logic [7:0]          sel_cnt;
    logic [ID_W-1:0]     sel_id;
    logic [ADDR_W-1:0]   gen_next;
    axi_resp_e           gen_resp;
    logic [IDX_W-1:0]    rd_idx;

    logic [DATA_W-1:0]   mem [DEPTH];

    // AR channel and queue status.
    assign full    = (count == QCNT_W'(AXI_AR_Q_DEPTH));
    assign empty   = (count == '0);
    assign arready = !full && !rst;
    assign ar_hs   = arvalid && arready;
    assign beat_hs = rvalid && rready;

    always_comb begin
        ar_in       = '0;
        ar_in.id    = AXI_ID_W'(arid);
        ar_in.addr  = AXI_ADDR_W'(araddr);
        ar_in.len   = arlen;
        ar_in.burst = axi_burst_e'(arburst);
    end

    assign head = q_mem[rd_ptr];

    // An arriving request bypasses an empty queue so it can start this cycle.
    assign start_avail = !empty || ar_hs;
    assign start_src   = empty ? ar_in : head;
    assign pop         = start && !empty;
    assign push        = ar_hs && !(start && empty);

    // AR queue storage (not reset).
    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr] <= ar_in;
        end
    end

    // AR queue pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + QPTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + QPTR_W'(1);
            end
            count <= count + QCNT_W'(push) - QCNT_W'(pop);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // FSM next state: start a burst, advance a beat, or chain into the next burst.
    always_comb begin
        state_n = state;
        start   = 1'b0;
        advance = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_avail) begin
                    start   = 1'b1;
                    state_n = ST_BURST;
                end
            end
            ST_BURST: begin
                if (beat_hs) begin
                    if (!rlast) begin
                        advance = 1'b1;
                    end else if (start_avail) begin
                        start = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign load = start || advance;

    // Beat being issued: either the first beat of a new burst or the successor.
    assign sel_addr  = start ? ADDR_W'(start_src.addr) : nxt_addr;
    assign sel_burst = start ? start_src.burst : ctx_burst;
    assign sel_len   = start ? start_src.len : ctx_len;
    assign sel_cnt   = start ? 8'd0 : cnt + 8'd1;
    assign sel_id    = start ? ID_W'(start_src.id) : ctx_id;
    assign rd_idx    = IDX_W'(sel_addr >> LSB);

    axi_rd_addr_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_addr_gen (
        .addr      (sel_addr),
        .burst     (sel_burst),
        .len       (sel_len),
        .cnt       (sel_cnt),
        .next_addr (gen_next),
        .resp      (gen_resp)
    );

    // Backdoor preload; a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_wdata;
        end
    end

    // R channel registers; only updated on load so a stalled beat stays put.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid    <= 1'b0;
            rlast     <= 1'b0;
            rid       <= '0;
            rdata     <= '0;
            rresp     <= '0;
            nxt_addr  <= '0;
            cnt       <= '0;
            ctx_len   <= '0;
            ctx_burst <= BURST_FIXED;
            ctx_id    <= '0;
        end else if (load) begin
            rvalid    <= 1'b1;
            rlast     <= (sel_cnt == sel_len);
            rid       <= sel_id;
            rresp     <= gen_resp;
            rdata     <= (gen_resp == RESP_OKAY) ? mem[rd_idx] : '0;
            nxt_addr  <= gen_next;
            cnt       <= sel_cnt;
            ctx_len   <= sel_len;
            ctx_burst <= sel_burst;
            ctx_id    <= sel_id;
        end else if (beat_hs) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_rd_mem_slave.sv
// Directed bench for axi_rd_mem_slave: a table of single-burst vectors plus
// hand-written sequences for backpressure, queue throughput, reset mid-burst
// and backdoor read-during-write. Word k is preloaded with 0xA000_0000 + k.
module tb_axi_rd_mem_slave;

    logic        clk;
    logic        rst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  arid;
    logic [15:0] araddr;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        bd_we;
    logic [9:0]  bd_addr;
    logic [31:0] bd_wdata;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  id;
        logic [15:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        int          n;
        logic [31:0] d [4];
        logic [1:0]  r [4];
    } vec_t;

    vec_t vecs [8];
    vec_t tail;

    axi_rd_mem_slave dut (
        .clk      (clk),
        .rst      (rst),
        .arvalid  (arvalid),
        .arready  (arready),
        .arid     (arid),
        .araddr   (araddr),
        .arlen    (arlen),
        .arburst  (arburst),
        .rvalid   (rvalid),
        .rready   (rready),
        .rid      (rid),
        .rdata    (rdata),
        .rresp    (rresp),
        .rlast    (rlast),
        .bd_we    (bd_we),
        .bd_addr  (bd_addr),
        .bd_wdata (bd_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] id, input logic [15:0] addr,
                                input logic [7:0] len, input logic [1:0] burst, input int n,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic [1:0] r0, input logic [1:0] r1,
                                input logic [1:0] r2, input logic [1:0] r3);
        vec_t v;
        v.id = id; v.addr = addr; v.len = len; v.burst = burst; v.n = n;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.r[0] = r0; v.r[1] = r1; v.r[2] = r2; v.r[3] = r3;
        return v;
    endfunction

    // Present one AR and return at the cycle after its handshake edge (+1).
    task automatic send_ar(input logic [3:0] id, input logic [15:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int t;
        t = 0;
        arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arburst = burst;
        while (!arready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("ar_accept", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    // Consume v.n beats with rready high and compare each one.
    task automatic collect(input string tag, input vec_t v);
        int t;
        for (int b = 0; b < v.n; b++) begin
            t = 0;
            while (!rvalid && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
            chk($sformatf("%s_b%0d_valid", tag, b), 32'(rvalid), 32'd1);
            chk($sformatf("%s_b%0d_data", tag, b), rdata, v.d[b]);
            chk($sformatf("%s_b%0d_resp", tag, b), 32'(rresp), 32'(v.r[b]));
            chk($sformatf("%s_b%0d_id", tag, b), 32'(rid), 32'(v.id));
            chk($sformatf("%s_b%0d_last", tag, b), 32'(rlast), 32'(b == v.n - 1));
            @(posedge clk); #1;
        end
        chk($sformatf("%s_idle", tag), 32'(rvalid), 32'd0);
    endtask

    initial begin
        int got;
        logic hs;

        vecs[0] = mk(4'd5, 16'h0010, 8'd3, 2'd1, 4, 32'hA0000004, 32'hA0000005,
                     32'hA0000006, 32'hA0000007, 2'd0, 2'd0, 2'd0, 2'd0);
        vecs[1] = mk(4'd6, 16'h0020, 8'd2, 2'd0, 3, 32'hA0000008, 32'hA0000008,
                     32'hA0000008, 32'h0, 2'd0, 2'd0, 2'd0, 2'd0);
        vecs[2] = mk(4'd7, 16'h0FF8, 8'd3, 2'd1, 4, 32'hA00003FE, 32'hA00003FF,
                     32'h0, 32'h0, 2'd0, 2'd0, 2'd3, 2'd3);
`ifdef AXI_RD_WRAP_EN
        vecs[3] = mk(4'd8, 16'h0018, 8'd3, 2'd2, 4, 32'hA0000006, 32'hA0000007,
                     32'hA0000004, 32'hA0000005, 2'd0, 2'd0, 2'd0, 2'd0);
`else
        vecs[3] = mk(4'd8, 16'h0018, 8'd3, 2'd2, 4, 32'h0, 32'h0, 32'h0, 32'h0,
                     2'd2, 2'd2, 2'd2, 2'd2);
`endif
        vecs[4] = mk(4'd9, 16'h0018, 8'd2, 2'd2, 3, 32'h0, 32'h0, 32'h0, 32'h0,
                     2'd2, 2'd2, 2'd2, 2'd0);
        vecs[5] = mk(4'd10, 16'h0030, 8'd1, 2'd3, 2, 32'h0, 32'h0, 32'h0, 32'h0,
                     2'd2, 2'd2, 2'd0, 2'd0);
        vecs[6] = mk(4'd11, 16'h001F, 8'd0, 2'd1, 1, 32'hA0000007, 32'h0, 32'h0, 32'h0,
                     2'd0, 2'd0, 2'd0, 2'd0);
        vecs[7] = mk(4'd12, 16'hFFFC, 8'd1, 2'd1, 2, 32'h0, 32'hA0000000, 32'h0, 32'h0,
                     2'd3, 2'd0, 2'd0, 2'd0);

        rst = 1'b1; arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; arburst = '0;
        rready = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rlast", 32'(rlast), 32'd0);
        chk("rst_rid", 32'(rid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rresp", 32'(rresp), 32'd0);
        rst = 1'b0;
        #1;
        chk("arready_after_rst", 32'(arready), 32'd1);

        // Preload.
        for (int k = 0; k < 1024; k++) begin
            bd_we = 1'b1; bd_addr = 10'(k); bd_wdata = 32'hA0000000 + 32'(k);
            @(posedge clk); #1;
        end
        bd_we = 1'b0;

        // Table-driven single bursts.
        rready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_ar(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].burst);
            chk($sformatf("v%0d_latency", i), 32'(rvalid), 32'd1);
            collect($sformatf("v%0d", i), vecs[i]);
        end

        // Backpressure: stall three cycles on beat 2 of an INCR burst.
        send_ar(4'd3, 16'h0010, 8'd3, 2'd1);
        chk("bp_b0_data", rdata, 32'hA0000004);
        @(posedge clk); #1;
        rready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_stall%0d_valid", s), 32'(rvalid), 32'd1);
            chk($sformatf("bp_stall%0d_data", s), rdata, 32'hA0000005);
            chk($sformatf("bp_stall%0d_last", s), 32'(rlast), 32'd0);
            chk($sformatf("bp_stall%0d_id", s), 32'(rid), 32'd3);
        end
        rready = 1'b1;
        tail = mk(4'd3, 16'h0, 8'd0, 2'd1, 3, 32'hA0000005, 32'hA0000006,
                  32'hA0000007, 32'h0, 2'd0, 2'd0, 2'd0, 2'd0);
        collect("bp", tail);

        // Queue fill: one burst stalled in flight, two queued, a fourth pending.
        rready = 1'b0;
        send_ar(4'd0, 16'h0000, 8'd0, 2'd1);
        send_ar(4'd1, 16'h0004, 8'd0, 2'd1);
        chk("q_one_arready", 32'(arready), 32'd1);
        send_ar(4'd2, 16'h0008, 8'd0, 2'd1);
        chk("q_full_arready", 32'(arready), 32'd0);
        arvalid = 1'b1; arid = 4'd3; araddr = 16'h000C; arlen = 8'd0; arburst = 2'd1;
        @(posedge clk); #1;
        chk("q_full_hold_arready", 32'(arready), 32'd0);
        chk("q_full_hold_rid", 32'(rid), 32'd0);
        rready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (rvalid) begin
                chk($sformatf("q_beat%0d_cycle", got), 32'(cyc), 32'(got));
                chk($sformatf("q_beat%0d_id", got), 32'(rid), 32'(got));
                chk($sformatf("q_beat%0d_data", got), rdata, 32'hA0000000 + 32'(got));
                chk($sformatf("q_beat%0d_last", got), 32'(rlast), 32'd1);
                got++;
            end
            hs = arvalid && arready;
            @(posedge clk); #1;
            if (hs) arvalid = 1'b0;
        end
        chk("q_beat_count", 32'(got), 32'd4);

        // Reset during beat 2 of an 8-beat burst.
        send_ar(4'd4, 16'h0000, 8'd7, 2'd1);
        chk("rstmid_b0_data", rdata, 32'hA0000000);
        @(posedge clk); #1;
        chk("rstmid_b1_data", rdata, 32'hA0000001);
        rst = 1'b1;
        #1;
        chk("rstmid_rvalid", 32'(rvalid), 32'd0);
        chk("rstmid_rlast", 32'(rlast), 32'd0);
        chk("rstmid_arready", 32'(arready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_idle", 32'(rvalid), 32'd0);
        send_ar(vecs[0].id, vecs[0].addr, vecs[0].len, vecs[0].burst);
        chk("post_rst_latency", 32'(rvalid), 32'd1);
        collect("post_rst", vecs[0]);

        // Backdoor write in the same cycle as the read returns the old word.
        bd_we = 1'b1; bd_addr = 10'd4; bd_wdata = 32'hDEADBEEF;
        send_ar(4'd1, 16'h0010, 8'd0, 2'd1);
        bd_we = 1'b0;
        chk("bd_same_cycle_old", rdata, 32'hA0000004);
        @(posedge clk); #1;
        send_ar(4'd2, 16'h0010, 8'd0, 2'd1);
        chk("bd_new_data", rdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        chk("bd_idle", 32'(rvalid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
